// File: rtl/dac_spi_pkg.sv
// ============================================================================
// Module      : dac_spi_pkg
// Description : Shared types and helpers for the dac_spi_tx serial DAC
//               transmitter (FSM state encoding, frame pad-width helper).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package dac_spi_pkg;

    // Transmitter FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Number of trailing zero bits after the power-down bits and data word.
    function automatic int pad_width(input int bits, input int dw);
        return bits - dw - 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_spi_tx_hb_tick_gen.sv
// ============================================================================
// Module      : hb_tick_gen
// Description : Enabled modulo-HBDIV counter. tick is high on the enabled
//               cycle in which the count sits at its terminal value; the
//               count then wraps to zero. With HBDIV=1 tick simply follows en.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hb_tick_gen
    import dac_spi_pkg::*;
#(
    parameter int HBDIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int             c_W  = (HBDIV > 1) ? $clog2(HBDIV) : 1;
    localparam logic [c_W-1:0] c_TC = c_W'(HBDIV - 1);

    logic [c_W-1:0] r_cnt;
    logic           w_tc;

    assign w_tc = (r_cnt == c_TC);
    assign tick = en & w_tc;

    // Count enabled cycles, wrapping at the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dac_spi_tx.sv
// ============================================================================
// Module      : dac_spi_tx
// Description : SPI master transmitter for a 12-bit serial DAC. Accepts one
//               {pd, din} sample per valid/ready handshake, shifts a BITS-long
//               frame MSB first on sck/sync_n/sdi (data changes on sck rise,
//               DAC samples on sck fall), then holds sync_n high for a
//               minimum gap before accepting the next sample.
//               Optional build macro DAC_SPI_TX_LDAC_EN adds an ldac_n load
//               strobe pulsed low for one half-bit at the start of the gap.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int HBDIV  = 1,
    parameter int BITS   = 16,
    parameter int DW     = 12,
    parameter int GAP_HB = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din,
    input  logic [1:0]    pd,
    output logic          busy,
    output logic          sck,
    output logic          sync_n,
    output logic          sdi
`ifdef DAC_SPI_TX_LDAC_EN
   ,output logic          ldac_n
`endif
);

    localparam int c_PAD = pad_width(BITS, DW);
`ifdef DAC_SPI_TX_LDAC_EN
    // The ldac_n pulse needs one full half-bit of gap to itself.
    localparam int c_GAP_LEN = (GAP_HB < 2) ? 2 : GAP_HB;
`else
    localparam int c_GAP_LEN = GAP_HB;
`endif

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_div_en;
    logic              w_hb_tick;
    logic              w_shift_en;
    logic              w_frame_end;
    logic              w_gap_en;
    logic              w_gap_end;
    logic              w_hs;

    logic [BITS-1:0]   w_frame;
    logic [BITS-1:0]   r_shreg;
    logic [BITS-1:0]   w_shreg_nxt;

    logic              r_din_ready, w_din_ready_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_sck,       w_sck_nxt;
    logic              r_sync_n,    w_sync_n_nxt;
    logic              r_sdi,       w_sdi_nxt;
`ifdef DAC_SPI_TX_LDAC_EN
    logic              r_ldac_n,    w_ldac_n_nxt;
`endif

    assign w_hs       = din_valid & r_din_ready & (r_state == IDLE);
    assign w_frame    = BITS'({pd, din}) << c_PAD;

    assign w_div_en   = (r_state != IDLE);
    assign w_shift_en = w_hb_tick & (r_state == SHIFT);
    assign w_gap_en   = w_hb_tick & (r_state == GAP);

    // Half-bit rate divider, free-running only while a frame or gap is active.
    hb_tick_gen #(.HBDIV(HBDIV)) u_hb_div (
        .clk  (clk),
        .rst  (rst),
        .en   (w_div_en),
        .tick (w_hb_tick)
    );

    // Half-bit index within the frame; tick marks the final half-bit.
    hb_tick_gen #(.HBDIV(2 * BITS)) u_hb_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (w_shift_en),
        .tick (w_frame_end)
    );

    // Half-bit count of the inter-frame gap.
    hb_tick_gen #(.HBDIV(c_GAP_LEN)) u_gap_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (w_gap_en),
        .tick (w_gap_end)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs)        w_state_nxt = SHIFT;
            SHIFT:   if (w_frame_end) w_state_nxt = GAP;
            GAP:     if (w_gap_end)   w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and the frame shift register.
    always_comb begin
        w_din_ready_nxt = r_din_ready;
        w_busy_nxt      = r_busy;
        w_sck_nxt       = r_sck;
        w_sync_n_nxt    = r_sync_n;
        w_sdi_nxt       = r_sdi;
        w_shreg_nxt     = r_shreg;
`ifdef DAC_SPI_TX_LDAC_EN
        w_ldac_n_nxt    = r_ldac_n;
`endif
        case (r_state)
            IDLE: begin
                w_din_ready_nxt = 1'b1;
                w_busy_nxt      = 1'b0;
                if (w_hs) begin
                    // First half-bit starts right away: MSB out, sck high.
                    w_din_ready_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_sync_n_nxt    = 1'b0;
                    w_sck_nxt       = 1'b1;
                    w_sdi_nxt       = w_frame[BITS-1];
                    w_shreg_nxt     = {w_frame[BITS-2:0], 1'b0};
                end
            end
            SHIFT: begin
                if (w_frame_end) begin
                    w_sync_n_nxt = 1'b1;
                    w_sck_nxt    = 1'b0;
                    w_sdi_nxt    = 1'b0;
`ifdef DAC_SPI_TX_LDAC_EN
                    w_ldac_n_nxt = 1'b0;
`endif
                end else if (w_hb_tick) begin
                    w_sck_nxt = ~r_sck;
                    // Data only moves as sck rises, so it is stable at the fall.
                    if (!r_sck) begin
                        w_sdi_nxt   = r_shreg[BITS-1];
                        w_shreg_nxt = {r_shreg[BITS-2:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (w_hb_tick) begin
`ifdef DAC_SPI_TX_LDAC_EN
                    w_ldac_n_nxt = 1'b1;
`endif
                    if (w_gap_end) begin
                        w_busy_nxt      = 1'b0;
                        w_din_ready_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_din_ready_nxt = 1'b0;
            end
        endcase
    end

    // Output and shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_sck       <= 1'b0;
            r_sync_n    <= 1'b1;
            r_sdi       <= 1'b0;
            r_shreg     <= '0;
        end else begin
            r_din_ready <= w_din_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_sck       <= w_sck_nxt;
            r_sync_n    <= w_sync_n_nxt;
            r_sdi       <= w_sdi_nxt;
            r_shreg     <= w_shreg_nxt;
        end
    end

`ifdef DAC_SPI_TX_LDAC_EN
    // Load strobe register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ldac_n <= 1'b1;
        end else begin
            r_ldac_n <= w_ldac_n_nxt;
        end
    end

    assign ldac_n = r_ldac_n;
`endif

    assign din_ready = r_din_ready;
    assign busy      = r_busy;
    assign sck       = r_sck;
    assign sync_n    = r_sync_n;
    assign sdi       = r_sdi;

endmodule

`default_nettype wire

// File: tb/tb_dac_spi_tx.sv
// ============================================================================
// Module      : tb_dac_spi_tx
// Description : Directed self-checking bench for dac_spi_tx. Two instances
//               (HBDIV=1 and HBDIV=3) share clock and reset; a bus monitor
//               reassembles the serial word at each sck falling edge.
//               Build macro DAC_SPI_TX_LDAC_EN enables the ldac_n checks.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dac_spi_tx;

    localparam int c_HB [2] = '{1, 3};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        din_valid [2];
    logic [11:0] din       [2];
    logic [1:0]  pd        [2];
    logic        din_ready [2];
    logic        busy      [2];
    logic        sck       [2];
    logic        sync_n    [2];
    logic        sdi       [2];
`ifdef DAC_SPI_TX_LDAC_EN
    logic        ldac_n    [2];
    int          ldac_cnt  [2];
    int          ldac_bad  [2];
`endif

    // Monitor state
    int          mon_frames [2];
    int          mon_low    [2];
    int          mon_bits   [2];
    int          mon_busy   [2];
    int          last_low   [2];
    int          last_bits  [2];
    int          last_busy  [2];
    int          high_cnt   [2];
    int          min_high   [2];
    logic [15:0] mon_sh     [2];
    logic [15:0] last_word  [2];
    logic        prev_sck   [2];
    logic        prev_sync  [2];
    logic        prev_busy  [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx #(.HBDIV(1), .BITS(16), .DW(12), .GAP_HB(2)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid[0]),
        .din_ready (din_ready[0]),
        .din       (din[0]),
        .pd        (pd[0]),
        .busy      (busy[0]),
        .sck       (sck[0]),
        .sync_n    (sync_n[0]),
        .sdi       (sdi[0])
`ifdef DAC_SPI_TX_LDAC_EN
       ,.ldac_n    (ldac_n[0])
`endif
    );

    dac_spi_tx #(.HBDIV(3), .BITS(16), .DW(12), .GAP_HB(2)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid[1]),
        .din_ready (din_ready[1]),
        .din       (din[1]),
        .pd        (pd[1]),
        .busy      (busy[1]),
        .sck       (sck[1]),
        .sync_n    (sync_n[1]),
        .sdi       (sdi[1])
`ifdef DAC_SPI_TX_LDAC_EN
       ,.ldac_n    (ldac_n[1])
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitor: samples mid-cycle, collects bits on sck falls, closes a
    // frame when sync_n rises.
    initial begin
        for (int d = 0; d < 2; d++) begin
            mon_frames[d] = 0;
            min_high[d]   = 1000;
            last_word[d]  = '0;
            last_low[d]   = 0;
            last_bits[d]  = 0;
            last_busy[d]  = 0;
`ifdef DAC_SPI_TX_LDAC_EN
            ldac_cnt[d]   = 0;
            ldac_bad[d]   = 0;
`endif
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    mon_sh[d]    = '0;
                    mon_low[d]   = 0;
                    mon_bits[d]  = 0;
                    mon_busy[d]  = 0;
                    high_cnt[d]  = 0;
                    prev_sck[d]  = 1'b0;
                    prev_sync[d] = 1'b1;
                    prev_busy[d] = 1'b0;
                end else begin
                    if (!sync_n[d]) mon_low[d]++;
                    if (prev_sck[d] && !sck[d]) begin
                        mon_sh[d] = {mon_sh[d][14:0], sdi[d]};
                        mon_bits[d]++;
                    end
                    if (!sync_n[d] && prev_sync[d]) begin
                        if (mon_frames[d] > 0 && high_cnt[d] < min_high[d])
                            min_high[d] = high_cnt[d];
`ifdef DAC_SPI_TX_LDAC_EN
                        ldac_cnt[d] = 0;
`endif
                    end
                    if (sync_n[d] && !prev_sync[d]) begin
                        last_word[d] = mon_sh[d];
                        last_low[d]  = mon_low[d];
                        last_bits[d] = mon_bits[d];
                        mon_frames[d]++;
                        mon_low[d]   = 0;
                        mon_bits[d]  = 0;
                        high_cnt[d]  = 0;
                    end
                    if (sync_n[d]) high_cnt[d]++;
                    if (busy[d]) mon_busy[d]++;
                    if (!busy[d] && prev_busy[d]) begin
                        last_busy[d] = mon_busy[d];
                        mon_busy[d]  = 0;
                    end
`ifdef DAC_SPI_TX_LDAC_EN
                    if (!ldac_n[d]) ldac_cnt[d]++;
                    if (!ldac_n[d] && !sync_n[d]) ldac_bad[d]++;
`endif
                    prev_sck[d]  = sck[d];
                    prev_sync[d] = sync_n[d];
                    prev_busy[d] = busy[d];
                end
            end
        end
    end

    // Wait (bounded) until the given instance offers din_ready.
    task automatic wait_idle(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (din_ready[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("timeout_ready", 32'd0, 32'd1);
    endtask

    // One handshake, then din/pd are changed while the frame is in flight.
    task automatic send_frame(input int d, input logic [11:0] v, input logic [1:0] p,
                              input logic [11:0] v_after);
        bit ok;
        int f0;
        wait_idle(d, ok);
        if (ok) begin
            f0           = mon_frames[d];
            din_valid[d] = 1'b1;
            din[d]       = v;
            pd[d]        = p;
            @(posedge clk);
            #1;
            din_valid[d] = 1'b0;
            din[d]       = v_after;
            pd[d]        = ~p;
            ok = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                #1;
                if (mon_frames[d] != f0 && din_ready[d]) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check_val("timeout_frame", 32'd0, 32'd1);
        end
    endtask

    initial begin : main
        bit ok;
        int f0;
        int hs [4];
        for (int d = 0; d < 2; d++) begin
            din_valid[d] = 1'b0;
            din[d]       = '0;
            pd[d]        = '0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready",  32'(din_ready[0]), 32'd0);
        check_val("rst_busy",   32'(busy[0]),      32'd0);
        check_val("rst_sck",    32'(sck[0]),       32'd0);
        check_val("rst_sync_n", 32'(sync_n[0]),    32'd1);
        check_val("rst_sdi",    32'(sdi[0]),       32'd0);
`ifdef DAC_SPI_TX_LDAC_EN
        check_val("rst_ldac_n", 32'(ldac_n[0]),    32'd1);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("ready_after_rst", 32'(din_ready[0]), 32'd1);

        // HBDIV=1, A5C, pd=0
        send_frame(0, 12'hA5C, 2'b00, 12'h3FF);
        check_val("a5c_word", 32'(last_word[0]), 32'h2970);
        check_val("a5c_low",  32'(last_low[0]),  32'd32);
        check_val("a5c_bits", 32'(last_bits[0]), 32'd16);
        check_val("a5c_busy", 32'(last_busy[0]), 32'd34);
        check_val("a5c_sdi_idle", 32'(sdi[0]),   32'd0);
`ifdef DAC_SPI_TX_LDAC_EN
        check_val("a5c_ldac_len", 32'(ldac_cnt[0]), 32'd1);
        check_val("a5c_ldac_bad", 32'(ldac_bad[0]), 32'd0);
`endif

        // HBDIV=3, FFF, pd=11
        send_frame(1, 12'hFFF, 2'b11, 12'h000);
        check_val("fff_word", 32'(last_word[1]), 32'hFFFC);
        check_val("fff_low",  32'(last_low[1]),  32'd96);
        check_val("fff_bits", 32'(last_bits[1]), 32'd16);
        check_val("fff_busy", 32'(last_busy[1]), 32'd102);
`ifdef DAC_SPI_TX_LDAC_EN
        check_val("fff_ldac_len", 32'(ldac_cnt[1]), 32'd3);
        check_val("fff_ldac_bad", 32'(ldac_bad[1]), 32'd0);
`endif

        // din changed to 000 during the frame after accepting 800
        send_frame(0, 12'h800, 2'b00, 12'h000);
        check_val("chg_word", 32'(last_word[0]), 32'h2000);

        // Reset at half-bit 10 of a frame
        wait_idle(0, ok);
        f0           = mon_frames[0];
        din_valid[0] = 1'b1;
        din[0]       = 12'h5A5;
        pd[0]        = 2'b01;
        @(posedge clk);
        #1;
        din_valid[0] = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("abort_sync_n", 32'(sync_n[0]),    32'd1);
        check_val("abort_sck",    32'(sck[0]),       32'd0);
        check_val("abort_busy",   32'(busy[0]),      32'd0);
        check_val("abort_ready",  32'(din_ready[0]), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("abort_no_frame", 32'(mon_frames[0] - f0), 32'd0);
        send_frame(0, 12'h123, 2'b01, 12'hEDC);
        check_val("post_abort_word", 32'(last_word[0]), 32'h448C);
        check_val("post_abort_low",  32'(last_low[0]),  32'd32);

        // Back-to-back with valid held high and incrementing din
        wait_idle(0, ok);
        min_high[0]  = 1000;
        f0           = mon_frames[0];
        din_valid[0] = 1'b1;
        din[0]       = 12'h100;
        pd[0]        = 2'b00;
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (din_ready[0]) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                check_val("b2b_timeout", 32'd0, 32'd1);
                break;
            end
            hs[k] = cyc;
            if (k > 0) begin
                check_val("b2b_interval", 32'(hs[k] - hs[k-1]), 32'd35);
                check_val("b2b_word", 32'(last_word[0]), 32'({2'b00, 12'(12'h100 + k - 1), 2'b00}));
            end
            @(posedge clk);
            #1;
            din[0] = din[0] + 12'd1;
        end
        din_valid[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (mon_frames[0] == f0 + 4 && din_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check_val("b2b_frames", 32'(mon_frames[0] - f0), 32'd4);
        check_val("b2b_last_word", 32'(last_word[0]), 32'h040C);
        check_val("b2b_min_gap_ok", 32'(min_high[0] >= 2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
